// File: rtl/dtc_pkg.sv
// dtc_pkg: shared types and helpers for the consumers of the dtc_split*
// decision-tree classifiers.
//   DTC_W        classifier thermometer-code width
//   level_t      decoded level, 0..DTC_W
//   agg_state_e  window aggregator FSM states
//   therm_legal  code -> {legal, level}
package dtc_pkg;

    localparam int DTC_W = 10;

    typedef logic [3:0] level_t;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } agg_state_e;

    typedef struct packed {
        logic   legal;
        level_t level;
    } therm_dec_t;

    // A legal thermometer code is a run of ones starting at bit 0, i.e.
    // code+1 is a power of two (or zero wrap for the all-ones code), so
    // code & (code+1) == 0. The level is the number of ones.
    function automatic therm_dec_t therm_legal(input logic [DTC_W-1:0] code);
        therm_dec_t       r;
        logic [DTC_W:0]   ext;
        ext     = {1'b0, code};
        r.legal = ((ext & (ext + {{DTC_W{1'b0}}, 1'b1})) == '0);
        r.level = '0;
        for (int i = 0; i < DTC_W; i++) begin
            r.level = r.level + level_t'(code[i]);
        end
        return r;
    endfunction

endpackage

// File: rtl/dtc_therm_window_agg_if.sv
// dtc_therm_window_agg_if: input stream (inp/in_valid/in_ready), result
// stream (out_*/out_valid/out_ready) and the illegal-code counter.
//   master  upstream/consumer side
//   slave   the aggregator
interface dtc_therm_window_agg_if
    import dtc_pkg::*;
#(
    parameter int W      = DTC_W,
    parameter int WINDOW = 8,
    parameter int ERR_W  = 8
);
    localparam int LW = $clog2(W + 1);
    localparam int SW = LW + $clog2(WINDOW) + 1;

    logic [W-1:0]     inp;
    logic             in_valid;
    logic             in_ready;
    logic [SW-1:0]    out_sum;
    logic [LW-1:0]    out_mean;
    logic [LW-1:0]    out_min;
    logic [LW-1:0]    out_max;
    logic             out_valid;
    logic             out_ready;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output inp, in_valid, out_ready,
        input  in_ready, out_sum, out_mean, out_min, out_max, out_valid, err_cnt
    );

    modport slave (
        input  inp, in_valid, out_ready,
        output in_ready, out_sum, out_mean, out_min, out_max, out_valid, err_cnt
    );

endinterface

// File: rtl/dtc_therm_decode.sv
// dtc_therm_decode: combinational thermometer-code checker.
//   code   in   DTC_W  thermometer code
//   legal  out  1      code is a contiguous run of ones from bit 0
//   level  out  4      number of ones (meaningful only when legal)
module dtc_therm_decode
    import dtc_pkg::*;
(
    input  logic [DTC_W-1:0] code,
    output logic             legal,
    output level_t           level
);
    therm_dec_t dec;

    assign dec   = therm_legal(code);
    assign legal = dec.legal;
    assign level = dec.level;

endmodule

// File: rtl/dtc_therm_window_agg.sv
// dtc_therm_window_agg: validates classifier thermometer codes, aggregates
// WINDOW legal samples into sum/mean/min/max and presents the result on a
// valid/ready port. Illegal codes only bump a saturating counter.
//   clk    in   rising-edge clock
//   rst_n  in   async active-low reset
//   clr    in   sync clear: drop partial window, zero err_cnt, drop result
//   bus    slave modport: inp/in_valid/in_ready, out_*/out_valid/out_ready,
//          err_cnt
module dtc_therm_window_agg
    import dtc_pkg::*;
#(
    parameter int W      = DTC_W,   // must match the decoder width
    parameter int WINDOW = 8,       // power of two, 2..256
    parameter int ERR_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    dtc_therm_window_agg_if.slave   bus
);
    localparam int LW = $clog2(W + 1);
    localparam int SH = $clog2(WINDOW);
    localparam int SW = LW + SH + 1;
    localparam int CW = SH + 1;

    agg_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    sum_q, sum_d;
    logic [LW-1:0]    min_q, min_d;
    logic [LW-1:0]    max_q, max_d;
    logic [SW-1:0]    osum_q, osum_d;
    logic [LW-1:0]    omean_q, omean_d;
    logic [LW-1:0]    omin_q, omin_d;
    logic [LW-1:0]    omax_q, omax_d;
    logic             ovld_q, ovld_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic             legal;
    level_t           level;
    logic [LW-1:0]    lvl;
    logic             xfer;
    logic [SW-1:0]    sum_nx;
    logic [LW-1:0]    min_nx, max_nx;
    logic [CW-1:0]    cnt_nx;
    logic [SW-1:0]    mean_w;

    dtc_therm_decode u_dec (
        .code  (bus.inp),
        .legal (legal),
        .level (level)
    );

    assign lvl  = LW'(level);
    assign xfer = bus.in_valid && (state_q == ACCUM);

    // Window values including the current sample; used both for the running
    // update and for the final load on the closing sample.
    assign sum_nx = sum_q + SW'(lvl);
    assign min_nx = (lvl < min_q) ? lvl : min_q;
    assign max_nx = (lvl > max_q) ? lvl : max_q;
    assign cnt_nx = cnt_q + CW'(1);
    assign mean_w = (sum_nx + SW'(WINDOW / 2)) >> SH;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        min_d   = min_q;
        max_d   = max_q;
        osum_d  = osum_q;
        omean_d = omean_q;
        omin_d  = omin_q;
        omax_d  = omax_q;
        ovld_d  = ovld_q;
        err_d   = err_q;
        if (clr) begin
            // Result registers keep their last value; only out_valid drops.
            state_d = ACCUM;
            cnt_d   = '0;
            sum_d   = '0;
            min_d   = LW'(W);
            max_d   = '0;
            ovld_d  = 1'b0;
            err_d   = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (xfer && legal) begin
                        if (cnt_nx == CW'(WINDOW)) begin
                            osum_d  = sum_nx;
                            omean_d = LW'(mean_w);
                            omin_d  = min_nx;
                            omax_d  = max_nx;
                            ovld_d  = 1'b1;
                            cnt_d   = '0;
                            sum_d   = '0;
                            min_d   = LW'(W);
                            max_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cnt_d = cnt_nx;
                            sum_d = sum_nx;
                            min_d = min_nx;
                            max_d = max_nx;
                        end
                    end else if (xfer && (err_q != '1)) begin
                        err_d = err_q + ERR_W'(1);
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        ovld_d  = 1'b0;
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            sum_q   <= '0;
            min_q   <= LW'(W);
            max_q   <= '0;
            osum_q  <= '0;
            omean_q <= '0;
            omin_q  <= '0;
            omax_q  <= '0;
            ovld_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            min_q   <= min_d;
            max_q   <= max_d;
            osum_q  <= osum_d;
            omean_q <= omean_d;
            omin_q  <= omin_d;
            omax_q  <= omax_d;
            ovld_q  <= ovld_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_sum   = osum_q;
    assign bus.out_mean  = omean_q;
    assign bus.out_min   = omin_q;
    assign bus.out_max   = omax_q;
    assign bus.out_valid = ovld_q;
    assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_dtc_therm_window_agg.sv
// tb_dtc_therm_window_agg: directed bench for dtc_therm_window_agg.
module tb_dtc_therm_window_agg;

    logic clk;
    logic rst_n;
    logic clr;
    int   n_chk;
    int   n_fail;

    dtc_therm_window_agg_if #(.W(10), .WINDOW(8), .ERR_W(8)) bus ();

    dtc_therm_window_agg #(.W(10), .WINDOW(8), .ERR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] therm(input int k);
        logic [31:0] t;
        t = (32'd1 << k) - 32'd1;
        return t[9:0];
    endfunction

    // Drive one code for one cycle (caller guarantees in_ready=1).
    task automatic send_code(input logic [9:0] code);
        bus.inp      = code;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_lvl(input int k);
        send_code(therm(k));
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr = 1'b0;
        bus.inp = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if ({bus.out_valid, bus.in_ready, bus.err_cnt} !== {1'b0, 1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: got vld=%0d rdy=%0d err=%0d, want 0 1 0",
                     bus.out_valid, bus.in_ready, bus.err_cnt);
        end
        n_chk++;
        if ({bus.out_sum, bus.out_mean, bus.out_min, bus.out_max} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_out: got sum=%0d mean=%0d min=%0d max=%0d, want all 0",
                     bus.out_sum, bus.out_mean, bus.out_min, bus.out_max);
        end
    endtask

    task automatic test_const_level();
        for (int i = 0; i < 8; i++) send_lvl(5);
        n_chk++;
        if ({bus.out_valid, bus.out_sum, bus.out_mean, bus.out_min, bus.out_max, bus.err_cnt}
            !== {1'b1, 8'd40, 4'd5, 4'd5, 4'd5, 8'd0}) begin
            n_fail++;
            $display("FAIL const5: got vld=%0d sum=%0d mean=%0d min=%0d max=%0d err=%0d, want 1 40 5 5 5 0",
                     bus.out_valid, bus.out_sum, bus.out_mean, bus.out_min, bus.out_max, bus.err_cnt);
        end
    endtask

    task automatic test_mixed_levels();
        int lv[8] = '{0, 1, 2, 3, 4, 5, 6, 10};
        consume();
        for (int i = 0; i < 8; i++) send_lvl(lv[i]);
        n_chk++;
        if ({bus.out_valid, bus.out_sum, bus.out_mean, bus.out_min, bus.out_max}
            !== {1'b1, 8'd31, 4'd4, 4'd0, 4'd10}) begin
            n_fail++;
            $display("FAIL mixed: got vld=%0d sum=%0d mean=%0d min=%0d max=%0d, want 1 31 4 0 10",
                     bus.out_valid, bus.out_sum, bus.out_mean, bus.out_min, bus.out_max);
        end
    endtask

    task automatic test_illegal();
        consume();
        send_lvl(2); send_lvl(2);
        send_code(10'b0000101111);
        send_lvl(3); send_lvl(3);
        send_code(10'b1000000000);
        send_lvl(4); send_lvl(4);
        // 8 transfers but only 6 legal: no result yet
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_early: got vld=%0d, want 0", bus.out_valid);
        end
        send_lvl(5); send_lvl(5);
        n_chk++;
        if ({bus.out_valid, bus.out_sum, bus.out_mean, bus.out_min, bus.out_max, bus.err_cnt}
            !== {1'b1, 8'd28, 4'd4, 4'd2, 4'd5, 8'd2}) begin
            n_fail++;
            $display("FAIL illegal: got vld=%0d sum=%0d mean=%0d min=%0d max=%0d err=%0d, want 1 28 4 2 5 2",
                     bus.out_valid, bus.out_sum, bus.out_mean, bus.out_min, bus.out_max, bus.err_cnt);
        end
    endtask

    task automatic test_backpressure();
        bus.inp = therm(10);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_chk++;
            if ({bus.out_valid, bus.in_ready, bus.out_sum, bus.out_mean, bus.out_min, bus.out_max}
                !== {1'b1, 1'b0, 8'd28, 4'd4, 4'd2, 4'd5}) begin
                n_fail++;
                $display("FAIL hold_%0d: got vld=%0d rdy=%0d sum=%0d mean=%0d min=%0d max=%0d, want 1 0 28 4 2 5",
                         i, bus.out_valid, bus.in_ready, bus.out_sum, bus.out_mean, bus.out_min, bus.out_max);
            end
        end
        bus.in_valid = 1'b0;
        consume();
        n_chk++;
        if ({bus.out_valid, bus.in_ready, bus.out_sum} !== {1'b0, 1'b1, 8'd28}) begin
            n_fail++;
            $display("FAIL release: got vld=%0d rdy=%0d sum=%0d, want 0 1 28",
                     bus.out_valid, bus.in_ready, bus.out_sum);
        end
        // Codes offered during HOLD must not have entered this window
        for (int i = 0; i < 8; i++) send_lvl(1);
        n_chk++;
        if ({bus.out_valid, bus.out_sum, bus.out_mean, bus.out_min, bus.out_max, bus.err_cnt}
            !== {1'b1, 8'd8, 4'd1, 4'd1, 4'd1, 8'd2}) begin
            n_fail++;
            $display("FAIL after_hold: got vld=%0d sum=%0d mean=%0d min=%0d max=%0d err=%0d, want 1 8 1 1 1 2",
                     bus.out_valid, bus.out_sum, bus.out_mean, bus.out_min, bus.out_max, bus.err_cnt);
        end
    endtask

    task automatic test_clr();
        consume();
        for (int i = 0; i < 5; i++) send_lvl(3);
        clr = 1'b1;
        bus.inp = therm(3);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        n_chk++;
        if ({bus.out_valid, bus.in_ready, bus.err_cnt} !== {1'b0, 1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL clr: got vld=%0d rdy=%0d err=%0d, want 0 1 0",
                     bus.out_valid, bus.in_ready, bus.err_cnt);
        end
        for (int i = 0; i < 3; i++) send_lvl(7);
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_partial: got vld=%0d, want 0", bus.out_valid);
        end
        for (int i = 0; i < 5; i++) send_lvl(7);
        n_chk++;
        if ({bus.out_valid, bus.out_sum, bus.out_mean, bus.out_min, bus.out_max}
            !== {1'b1, 8'd56, 4'd7, 4'd7, 4'd7}) begin
            n_fail++;
            $display("FAIL clr_next: got vld=%0d sum=%0d mean=%0d min=%0d max=%0d, want 1 56 7 7 7",
                     bus.out_valid, bus.out_sum, bus.out_mean, bus.out_min, bus.out_max);
        end
    endtask

    task automatic test_async_reset();
        consume();
        send_code(10'b0000000010);
        send_lvl(4); send_lvl(4); send_lvl(4);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({bus.out_valid, bus.in_ready, bus.out_sum, bus.err_cnt} !== {1'b0, 1'b1, 8'd56 ^ 8'd56, 8'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_window: got vld=%0d rdy=%0d sum=%0d err=%0d, want 0 1 0 0",
                     bus.out_valid, bus.in_ready, bus.out_sum, bus.err_cnt);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) send_lvl(6);
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_partial: got vld=%0d, want 0", bus.out_valid);
        end
        send_lvl(6);
        n_chk++;
        if ({bus.out_valid, bus.out_sum, bus.out_mean} !== {1'b1, 8'd48, 4'd6}) begin
            n_fail++;
            $display("FAIL rst_next: got vld=%0d sum=%0d mean=%0d, want 1 48 6",
                     bus.out_valid, bus.out_sum, bus.out_mean);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({bus.out_valid, bus.in_ready, bus.out_sum, bus.out_mean, bus.out_min, bus.out_max}
            !== {1'b0, 1'b1, 8'd0, 4'd0, 4'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_hold: got vld=%0d rdy=%0d sum=%0d mean=%0d min=%0d max=%0d, want 0 1 0 0 0 0",
                     bus.out_valid, bus.in_ready, bus.out_sum, bus.out_mean, bus.out_min, bus.out_max);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 255; i++) send_code(10'b0000101111);
        n_chk++;
        if (bus.err_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL err_255: got %0d, want 255", bus.err_cnt);
        end
        send_code(10'b1000000000);
        n_chk++;
        if ({bus.err_cnt, bus.out_valid} !== {8'd255, 1'b0}) begin
            n_fail++;
            $display("FAIL err_sat: got err=%0d vld=%0d, want 255 0", bus.err_cnt, bus.out_valid);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        test_reset();
        test_const_level();
        test_mixed_levels();
        test_illegal();
        test_backpressure();
        test_clr();
        test_async_reset();
        test_err_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
